dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter: DMC_TIMEOUT, 255, maximum number of cycles to wait in MEM_REQ for mem_ack before faulting.
REQ-002 Parameter: DMC_CNT_SZ, 8, width of the timeout counter; must satisfy 2**DMC_CNT_SZ > DMC_TIMEOUT.
REQ-003 Port: clk_in  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port: reset_in  input  1  synchronous, active-high reset.
REQ-005 Port: DC_bus  L1DC.slave  -  request side, driven by the Load/Store queue.
  - Inputs: req, req_data.{rd, wr, rw_addr[31:0], wr_data[31:0], size, zero_ext, inv_flag}.
  - Outputs: ack, ack_data.{rd_data[31:0], fault}.
REQ-006 Port: mem_req  output  1  system memory cycle request.
REQ-007 Port: mem_we  output  1  1 = write, 0 = read.
REQ-008 Port: mem_addr  output  32  word-aligned address; bits [1:0] = 0.
REQ-009 Port: mem_be  output  4  byte enables, one per byte lane.
REQ-010 Port: mem_wdata  output  32  lane-aligned write data.
REQ-011 Port: mem_ack  input  1  one-cycle completion strobe from system memory.
REQ-012 Port: mem_rdata  input  32  read data, valid when mem_ack = 1.
REQ-013 Port: mem_err  input  1  bus error, valid when mem_ack = 1.

Function
REQ-014 FSM states: IDLE, MEM_REQ, RESP; requests are accepted only in IDLE.
REQ-015 In IDLE with DC_bus.req = 1, the request is classified in that cycle and all request fields are registered.
REQ-016 Accepted request with a legal size/alignment and rd xor wr = 1: next state MEM_REQ.
REQ-017 Accepted request that is illegal: next state RESP with fault = 1, and no memory cycle is issued.
  - Illegal = size not in {1,2,4}, size 2 with addr[0] = 1, size 4 with addr[1:0] != 0, or rd = wr.
REQ-018 Accepted request with inv_flag = 1: next state RESP with fault = 0 and rd_data = 0; no memory cycle.
REQ-019 In MEM_REQ: mem_req = 1, and mem_we/mem_addr/mem_be/mem_wdata come from registered values and stay stable until mem_ack.
REQ-020 Byte enables: size 1 -> 4'b0001 << addr[1:0]; size 2 -> addr[1] ? 4'b1100 : 4'b0011; size 4 -> 4'b1111.
REQ-021 Write data: the byte is replicated to all four lanes (size 1), the halfword to both halves (size 2), or passed through (size 4).
REQ-022 Read data: mem_rdata is shifted right by addr[1:0]*8, then zero-extended (zero_ext = 1) or sign-extended from bit 7 (size 1) or bit 15 (size 2); size 4 is unchanged.
REQ-023 mem_ack in MEM_REQ: capture the extended rd_data (writes: 0) and fault = mem_err; mem_req deasserts the next cycle; next state RESP.
REQ-024 Timeout counter: clears on entry to MEM_REQ and increments each MEM_REQ cycle without mem_ack.
REQ-025 When the count reaches DMC_TIMEOUT without mem_ack: mem_req drops, next state RESP with fault = 1.
REQ-026 If mem_ack arrives in the same cycle the count reaches DMC_TIMEOUT, mem_ack wins and the normal response is returned.
REQ-027 In RESP, DC_bus.ack = 1 for exactly one cycle with registered ack_data; next state IDLE.
  - DC_bus.req still being high in RESP is ignored.
REQ-028 Latency: a legal memory access with req sampled in cycle n drives mem_req from cycle n+1; mem_ack in cycle m gives DC_bus.ack in cycle m+1.
REQ-029 Latency: illegal and inv_flag requests give DC_bus.ack in cycle n+1.
REQ-030 mem_ack received outside MEM_REQ is ignored.
REQ-031 All outputs are registered; there is no combinational path from any input to any output.

Reset
REQ-032 On reset_in = 1, the next state is IDLE, and the counter and all registered request/response fields are 0.
REQ-033 Output values during/after reset: mem_req = 0, mem_we = 0, mem_addr = 0, mem_be = 0, mem_wdata = 0, DC_bus.ack = 0, ack_data = 0.
REQ-034 Reset during MEM_REQ or RESP abandons the operation: mem_req drops the next cycle and no DC_bus.ack is issued.

Structure
REQ-035 The DMC_State enum and the DMC_TIMEOUT default belong in cpu_params_pkg.
REQ-036 A memory response struct (rdata, err) belongs in cpu_structs_pkg.
REQ-037 Sub-module dmc_lane_align: combinational byte-enable generation, write replication, read shift/extend, and illegal detection; dmem_ctrl instantiates it once.

Verification
REQ-038 Byte load, with memory returning mem_rdata = 32'h80FF_1234 one cycle later:
  - rd, addr = 32'h0000_1003, size 1, zero_ext 0 -> mem_be 4'b1000, mem_addr 32'h0000_1000; rd_data = 32'hFFFF_FF80, fault 0.
REQ-039 Halfword store: wr, addr = 32'h0000_2002, size 2, wr_data = 32'h0000_BEEF -> mem_we 1, mem_be 4'b1100, mem_wdata 32'hBEEF_BEEF; ack with fault 0.
REQ-040 Misaligned word load: rd, addr = 32'h0000_3001, size 4 -> mem_req never asserts; ack in cycle n+1 with fault 1.
REQ-041 Timeout: word load with DMC_TIMEOUT = 4 and mem_ack never asserted -> mem_req high for 4 cycles, then drops; ack with fault 1.
REQ-042 Reset while mem_req = 1 -> mem_req is 0 the next cycle and ack is never seen; a following legal request completes normally.
REQ-043 Back-to-back: req held high through ack, then a new request in the following IDLE cycle -> exactly one ack per request, none lost or duplicated.

Source files
------------

// File: rtl/cpu_params_pkg.sv
// cpu_params_pkg
//   Shared CPU-level parameters and state encodings.
//   - DMC_State            : data-memory controller FSM states
//   - DMC_TIMEOUT_DEFAULT  : default memory-cycle timeout (cycles)
//   - DMC_CNT_SZ_DEFAULT   : default width of the timeout counter
package cpu_params_pkg;

    typedef enum logic [1:0] {
        DMC_IDLE    = 2'd0,
        DMC_MEM_REQ = 2'd1,
        DMC_RESP    = 2'd2
    } DMC_State;

    localparam int DMC_TIMEOUT_DEFAULT = 255;
    localparam int DMC_CNT_SZ_DEFAULT  = 8;

endpackage

// File: rtl/cpu_structs_pkg.sv
// cpu_structs_pkg
//   Shared CPU-level structures.
//   - l1dc_req_t : request from the Load/Store queue to the data-memory controller
//   - l1dc_ack_t : response returned to the Load/Store queue
//   - mem_rsp_t  : response from system memory (read data + bus error)
package cpu_structs_pkg;

    // size is a byte count; only 1, 2 and 4 are legal.
    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] rw_addr;
        logic [31:0] wr_data;
        logic [2:0]  size;
        logic        zero_ext;
        logic        inv_flag;
    } l1dc_req_t;

    typedef struct packed {
        logic [31:0] rd_data;
        logic        fault;
    } l1dc_ack_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } mem_rsp_t;

endpackage

// File: rtl/l1dc_if.sv
// L1DC
//   Request/response link between the Load/Store queue (master) and the
//   data-memory controller (slave).
//   req/req_data : request strobe and fields (master -> slave)
//   ack/ack_data : one-cycle response strobe and fields (slave -> master)
interface L1DC;
    import cpu_structs_pkg::*;

    logic      req;
    l1dc_req_t req_data;
    logic      ack;
    l1dc_ack_t ack_data;

    modport master (output req, output req_data, input ack, input ack_data);
    modport slave  (input req, input req_data, output ack, output ack_data);

endinterface

// File: rtl/dmc_lane_align.sv
// dmc_lane_align
//   Purely combinational lane handling for the data-memory controller.
//   Request side (classifies an incoming request):
//     rd, wr, addr_lo[1:0], size[2:0], wr_data[31:0]
//       -> be[3:0], wdata[31:0], illegal
//   Response side (formats read data of the registered request):
//     rsp_off[1:0], rsp_size[2:0], rsp_zext, rdata[31:0]
//       -> rdata_ext[31:0]
module dmc_lane_align (
    input  logic        rd,
    input  logic        wr,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  size,
    input  logic [31:0] wr_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        illegal,
    input  logic [1:0]  rsp_off,
    input  logic [2:0]  rsp_size,
    input  logic        rsp_zext,
    input  logic [31:0] rdata,
    output logic [31:0] rdata_ext
);

    logic        misaligned;
    logic [31:0] shifted;

    always_comb begin
        misaligned = 1'b1;
        be         = 4'b0000;
        wdata      = wr_data;
        case (size)
            3'd1: begin
                misaligned = 1'b0;
                be         = 4'b0001 << addr_lo;
                wdata      = {4{wr_data[7:0]}};
            end
            3'd2: begin
                misaligned = addr_lo[0];
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{wr_data[15:0]}};
            end
            3'd4: begin
                misaligned = |addr_lo;
                be         = 4'b1111;
            end
            default: misaligned = 1'b1;
        endcase
        // Exactly one of rd/wr must be set for a real access.
        illegal = misaligned | (rd == wr);
    end

    always_comb begin
        shifted = rdata >> {rsp_off, 3'b000};
        case (rsp_size)
            3'd1:    rdata_ext = rsp_zext ? {24'h0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            3'd2:    rdata_ext = rsp_zext ? {16'h0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            default: rdata_ext = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl
//   Data-memory controller: accepts one Load/Store request at a time on
//   DC_bus, runs a single system-memory cycle with lane alignment, and
//   returns a one-cycle ack with read data / fault.
//   Ports:
//     clk_in, reset_in (sync, active high)
//     DC_bus           : L1DC slave (req/req_data in, ack/ack_data out)
//     mem_req, mem_we, mem_addr, mem_be, mem_wdata : memory request (registered)
//     mem_ack, mem_rdata, mem_err                  : memory response
//   Illegal and invalidate requests are answered without a memory cycle.
//   A memory cycle that sees no mem_ack for DMC_TIMEOUT cycles ends in a fault.
module dmem_ctrl
    import cpu_params_pkg::*;
    import cpu_structs_pkg::*;
#(
    parameter int DMC_TIMEOUT = DMC_TIMEOUT_DEFAULT,
    parameter int DMC_CNT_SZ  = DMC_CNT_SZ_DEFAULT
) (
    input  logic        clk_in,
    input  logic        reset_in,
    L1DC.slave          DC_bus,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err
);

    // Count value in the last permitted MEM_REQ cycle; without mem_ack in
    // that cycle the count reaches DMC_TIMEOUT and the access faults.
    localparam logic [DMC_CNT_SZ-1:0] CNT_LAST = DMC_CNT_SZ'(DMC_TIMEOUT - 1);

    DMC_State              state;
    logic [DMC_CNT_SZ-1:0] cnt;

    logic                  rq_rd;
    logic [1:0]            rq_off;
    logic [2:0]            rq_size;
    logic                  rq_zext;

    logic                  ack;
    l1dc_ack_t             ack_data;

    mem_rsp_t              rsp;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic                  illegal;
    logic [31:0]           rdata_ext;

    assign rsp = '{rdata: mem_rdata, err: mem_err};

    dmc_lane_align u_lane_align (
        .rd        (DC_bus.req_data.rd),
        .wr        (DC_bus.req_data.wr),
        .addr_lo   (DC_bus.req_data.rw_addr[1:0]),
        .size      (DC_bus.req_data.size),
        .wr_data   (DC_bus.req_data.wr_data),
        .be        (be),
        .wdata     (wdata),
        .illegal   (illegal),
        .rsp_off   (rq_off),
        .rsp_size  (rq_size),
        .rsp_zext  (rq_zext),
        .rdata     (rsp.rdata),
        .rdata_ext (rdata_ext)
    );

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state     <= DMC_IDLE;
            cnt       <= '0;
            rq_rd     <= 1'b0;
            rq_off    <= 2'b00;
            rq_size   <= 3'd0;
            rq_zext   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
            ack       <= 1'b0;
            ack_data  <= '0;
        end else begin
            ack <= 1'b0;
            case (state)
                DMC_IDLE: begin
                    if (DC_bus.req) begin
                        rq_rd     <= DC_bus.req_data.rd;
                        rq_off    <= DC_bus.req_data.rw_addr[1:0];
                        rq_size   <= DC_bus.req_data.size;
                        rq_zext   <= DC_bus.req_data.zero_ext;
                        mem_we    <= DC_bus.req_data.wr;
                        mem_addr  <= {DC_bus.req_data.rw_addr[31:2], 2'b00};
                        mem_be    <= be;
                        mem_wdata <= wdata;
                        // Invalidate is answered directly, even if the
                        // accompanying access fields would be illegal.
                        if (DC_bus.req_data.inv_flag) begin
                            ack      <= 1'b1;
                            ack_data <= '{rd_data: 32'h0, fault: 1'b0};
                            state    <= DMC_RESP;
                        end else if (illegal) begin
                            ack      <= 1'b1;
                            ack_data <= '{rd_data: 32'h0, fault: 1'b1};
                            state    <= DMC_RESP;
                        end else begin
                            mem_req <= 1'b1;
                            cnt     <= '0;
                            state   <= DMC_MEM_REQ;
                        end
                    end
                end
                DMC_MEM_REQ: begin
                    // mem_ack is checked first so it wins over a timeout in
                    // the same cycle.
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        ack      <= 1'b1;
                        ack_data <= '{rd_data: (rq_rd ? rdata_ext : 32'h0),
                                      fault:   rsp.err};
                        state    <= DMC_RESP;
                    end else if (cnt == CNT_LAST) begin
                        mem_req  <= 1'b0;
                        cnt      <= cnt + 1'b1;
                        ack      <= 1'b1;
                        ack_data <= '{rd_data: 32'h0, fault: 1'b1};
                        state    <= DMC_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DMC_RESP: begin
                    state <= DMC_IDLE;
                end
                default: begin
                    state <= DMC_IDLE;
                end
            endcase
        end
    end

    assign DC_bus.ack      = ack;
    assign DC_bus.ack_data = ack_data;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl
//   Directed bench for dmem_ctrl. Each request is turned into a time-indexed
//   schedule of expected outputs (which cycles carry mem_req and with what
//   lanes, which cycle carries ack and with what data); one compare process
//   checks the DUT against that schedule every cycle. A few literal checks
//   pin the model to hand-computed values.
module tb_dmem_ctrl;
    import cpu_structs_pkg::*;

    localparam int T    = 4;
    localparam int MAXC = 2048;

    logic        clk_in   = 1'b0;
    logic        reset_in = 1'b1;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack   = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_err   = 1'b0;

    L1DC dc_bus ();

    dmem_ctrl #(.DMC_TIMEOUT(T), .DMC_CNT_SZ(8)) dut (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .DC_bus    (dc_bus),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .mem_err   (mem_err)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc++;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    bit          exp_mreq  [MAXC];
    bit          exp_we    [MAXC];
    logic [31:0] exp_addr  [MAXC];
    logic [3:0]  exp_be    [MAXC];
    logic [31:0] exp_wdata [MAXC];
    bit          exp_ack   [MAXC];
    logic [31:0] exp_rd    [MAXC];
    bit          exp_fault [MAXC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_illegal(input bit rd, input bit wr, input logic [31:0] addr, input int size);
        if (rd == wr) return 1'b1;
        if (size == 1) return 1'b0;
        if (size == 2) return addr[0];
        if (size == 4) return addr[1:0] != 2'b00;
        return 1'b1;
    endfunction

    function automatic logic [3:0] model_be(input logic [31:0] addr, input int size);
        logic [3:0] b = 4'b0000;
        for (int i = 0; i < size; i++) b[int'(addr[1:0]) + i] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] wd, input int size);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) w[8*j +: 8] = wd[8*(j % size) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] rdata, input logic [31:0] addr,
                                             input int size, input bit zext);
        logic [31:0] v = 32'h0;
        int off = int'(addr[1:0]);
        for (int i = 0; i < size; i++) v[8*i +: 8] = rdata[8*(off + i) +: 8];
        if (size < 4 && !zext && v[8*size - 1])
            for (int b = 8*size; b < 32; b++) v[b] = 1'b1;
        return v;
    endfunction

    task automatic sched_mem(input int first, input int k, input bit wr, input logic [31:0] addr,
                             input int size, input logic [31:0] wd);
        for (int c = first; c < first + k; c++) begin
            exp_mreq[c]  = 1'b1;
            exp_we[c]    = wr;
            exp_addr[c]  = addr & ~32'h3;
            exp_be[c]    = model_be(addr, size);
            exp_wdata[c] = model_wdata(wd, size);
        end
    endtask

    task automatic clear_from(input int c0);
        for (int c = c0; c < MAXC; c++) begin
            exp_mreq[c] = 1'b0;
            exp_ack[c]  = 1'b0;
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk_in) begin
        if (chk_en && cyc < MAXC) begin
            chk("mem_req", 32'(mem_req), 32'(exp_mreq[cyc]));
            if (exp_mreq[cyc]) begin
                chk("mem_we",    32'(mem_we), 32'(exp_we[cyc]));
                chk("mem_addr",  mem_addr,    exp_addr[cyc]);
                chk("mem_be",    32'(mem_be), 32'(exp_be[cyc]));
                chk("mem_wdata", mem_wdata,   exp_wdata[cyc]);
            end
            chk("ack", 32'(dc_bus.ack), 32'(exp_ack[cyc]));
            if (exp_ack[cyc]) begin
                chk("rd_data", dc_bus.ack_data.rd_data,     exp_rd[cyc]);
                chk("fault",   32'(dc_bus.ack_data.fault),  32'(exp_fault[cyc]));
            end
        end
    end

    // ---------------- observation for literal checks ----------------
    int          run = 0, last_run = 0, n_acks = 0, mreq_total = 0;
    logic [3:0]  seen_be;
    logic [31:0] seen_addr, seen_wdata, seen_rd;
    logic        seen_we, seen_fault;

    always @(negedge clk_in) begin
        if (mem_req === 1'b1) begin
            run++;
            mreq_total++;
            seen_be    = mem_be;
            seen_addr  = mem_addr;
            seen_wdata = mem_wdata;
            seen_we    = mem_we;
        end else if (run != 0) begin
            last_run = run;
            run      = 0;
        end
        if (dc_bus.ack === 1'b1) begin
            n_acks++;
            seen_rd    = dc_bus.ack_data.rd_data;
            seen_fault = dc_bus.ack_data.fault;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_cycle();
        @(posedge clk_in);
        #1;
    endtask

    // ack_at: mem_ack in the ack_at-th MEM_REQ cycle (0 = never).
    task automatic access(input bit rd, input bit wr, input logic [31:0] addr, input int size,
                          input bit zext, input bit inv, input logic [31:0] wd, input int ack_at,
                          input logic [31:0] rdata, input bit err, input bit hold);
        int n, k, a;
        bit mem_op, acked;
        n = cyc;
        dc_bus.req      = 1'b1;
        dc_bus.req_data = '{rd: rd, wr: wr, rw_addr: addr, wr_data: wd, size: 3'(size),
                            zero_ext: zext, inv_flag: inv};
        mem_op = !inv && !is_illegal(rd, wr, addr, size);
        acked  = ack_at >= 1 && ack_at <= T;
        if (!mem_op) begin
            a            = n + 1;
            exp_ack[a]   = 1'b1;
            exp_rd[a]    = 32'h0;
            exp_fault[a] = !inv;
        end else begin
            k = acked ? ack_at : T;
            sched_mem(n + 1, k, wr, addr, size, wd);
            a          = n + k + 1;
            exp_ack[a] = 1'b1;
            if (acked) begin
                exp_fault[a] = err;
                exp_rd[a]    = rd ? model_rd(rdata, addr, size, zext) : 32'h0;
            end else begin
                exp_fault[a] = 1'b1;
                exp_rd[a]    = 32'h0;
            end
        end
        wait_cycle();
        if (!hold) dc_bus.req = 1'b0;
        while (cyc <= a) begin
            mem_ack   = mem_op && ack_at >= 1 && cyc == n + ack_at;
            mem_rdata = rdata;
            mem_err   = err;
            wait_cycle();
        end
        mem_ack = 1'b0;
        mem_err = 1'b0;
    endtask

    int n0, base;

    initial begin
        dc_bus.req      = 1'b0;
        dc_bus.req_data = '0;
        wait_cycle();
        chk_en = 1'b1;
        wait_cycle();
        wait_cycle();
        chk("rst_mem_we",    32'(mem_we),                  32'h0);
        chk("rst_mem_addr",  mem_addr,                     32'h0);
        chk("rst_mem_be",    32'(mem_be),                  32'h0);
        chk("rst_mem_wdata", mem_wdata,                    32'h0);
        chk("rst_rd_data",   dc_bus.ack_data.rd_data,      32'h0);
        chk("rst_fault",     32'(dc_bus.ack_data.fault),   32'h0);
        reset_in = 1'b0;
        wait_cycle();

        // byte load, sign-extended
        access(1, 0, 32'h0000_1003, 1, 0, 0, 32'h0, 1, 32'h80FF_1234, 0, 0);
        chk("lb_be",    32'(seen_be),    32'h8);
        chk("lb_addr",  seen_addr,       32'h0000_1000);
        chk("lb_rd",    seen_rd,         32'hFFFF_FF80);
        chk("lb_fault", 32'(seen_fault), 32'h0);

        // halfword store
        access(0, 1, 32'h0000_2002, 2, 0, 0, 32'h0000_BEEF, 2, 32'hDEAD_BEEF, 0, 0);
        chk("sh_we",    32'(seen_we),    32'h1);
        chk("sh_be",    32'(seen_be),    32'hC);
        chk("sh_wdata", seen_wdata,      32'hBEEF_BEEF);
        chk("sh_rd",    seen_rd,         32'h0);

        // misaligned word load: no memory cycle
        n0 = mreq_total;
        access(1, 0, 32'h0000_3001, 4, 0, 0, 32'h0, 1, 32'h0, 0, 0);
        chk("mis_no_mreq", 32'(mreq_total - n0), 32'h0);
        chk("mis_fault",   32'(seen_fault),      32'h1);

        // timeout
        access(1, 0, 32'h0000_4000, 4, 0, 0, 32'h0, 0, 32'h1111_1111, 0, 0);
        chk("to_run",   32'(last_run),   32'd4);
        chk("to_fault", 32'(seen_fault), 32'h1);

        // mem_ack in the last allowed cycle wins over the timeout
        access(1, 0, 32'h0000_4004, 4, 0, 0, 32'h0, T, 32'hCAFE_F00D, 0, 0);
        chk("edge_rd", seen_rd, 32'hCAFE_F00D);

        // mem_ack arriving one cycle too late lands in RESP and is ignored
        access(1, 0, 32'h0000_4008, 4, 0, 0, 32'h0, T + 1, 32'h1234_5678, 0, 0);

        // extension variants
        access(1, 0, 32'h0000_5002, 2, 0, 0, 32'h0, 3, 32'h8001_7FFF, 0, 0);
        chk("lh_sext", seen_rd, 32'hFFFF_8001);
        access(1, 0, 32'h0000_5002, 2, 1, 0, 32'h0, 1, 32'h8001_7FFF, 0, 0);
        access(1, 0, 32'h0000_5001, 1, 1, 0, 32'h0, 2, 32'h0000_F200, 0, 0);
        access(1, 0, 32'h0000_5000, 2, 0, 0, 32'h0, 1, 32'h0000_7FFF, 0, 0);

        // stores
        access(0, 1, 32'h0000_6000, 4, 0, 0, 32'h0123_4567, 1, 32'hFFFF_FFFF, 0, 0);
        access(0, 1, 32'h0000_6006, 1, 0, 0, 32'h0000_00A5, 2, 32'h0, 0, 0);
        chk("sb_be",    32'(seen_be), 32'h4);
        chk("sb_wdata", seen_wdata,   32'hA5A5_A5A5);

        // illegal requests
        access(1, 0, 32'h0000_7000, 3, 0, 0, 32'h0, 1, 32'h0, 0, 0);
        access(1, 1, 32'h0000_7000, 4, 0, 0, 32'h0, 1, 32'h0, 0, 0);
        access(0, 0, 32'h0000_7000, 4, 0, 0, 32'h0, 1, 32'h0, 0, 0);
        access(0, 1, 32'h0000_7001, 2, 0, 0, 32'h0, 1, 32'h0, 0, 0);

        // invalidate
        access(1, 0, 32'h0000_8000, 4, 0, 1, 32'h0, 1, 32'hFFFF_FFFF, 0, 0);
        chk("inv_fault", 32'(seen_fault), 32'h0);

        // bus error
        access(1, 0, 32'h0000_9000, 4, 0, 0, 32'h0, 2, 32'h5555_AAAA, 1, 0);

        // spurious mem_ack while idle
        n0 = n_acks;
        mem_ack = 1'b1;
        wait_cycle();
        wait_cycle();
        mem_ack = 1'b0;
        wait_cycle();
        chk("idle_ack_ignored", 32'(n_acks - n0), 32'h0);

        // reset during MEM_REQ
        n0   = n_acks;
        base = cyc;
        dc_bus.req      = 1'b1;
        dc_bus.req_data = '{rd: 1'b1, wr: 1'b0, rw_addr: 32'h0000_A000, wr_data: 32'h0,
                            size: 3'd4, zero_ext: 1'b0, inv_flag: 1'b0};
        sched_mem(base + 1, 2, 0, 32'h0000_A000, 4, 32'h0);
        wait_cycle();
        dc_bus.req = 1'b0;
        wait_cycle();
        reset_in = 1'b1;
        clear_from(base + 3);
        wait_cycle();
        reset_in = 1'b0;
        wait_cycle();
        wait_cycle();
        chk("rst_no_ack", 32'(n_acks - n0), 32'h0);
        access(1, 0, 32'h0000_A004, 4, 0, 0, 32'h0, 2, 32'h0BAD_F00D, 0, 0);
        chk("post_rst_rd", seen_rd, 32'h0BAD_F00D);

        // back-to-back with req held high through each response
        n0 = n_acks;
        access(1, 0, 32'h0000_B000, 4, 0, 0, 32'h0, 1, 32'h1111_2222, 0, 1);
        access(0, 1, 32'h0000_B004, 4, 0, 0, 32'h3333_4444, 3, 32'h0, 0, 1);
        access(1, 0, 32'h0000_B001, 4, 0, 0, 32'h0, 1, 32'h0, 0, 1);
        access(1, 0, 32'h0000_B003, 1, 1, 0, 32'h0, 1, 32'h7700_0000, 0, 0);
        chk("b2b_acks", 32'(n_acks - n0), 32'd4);

        wait_cycle();
        wait_cycle();
        wait_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
